uart_rx_core: RTL
=================

Name: uart_rx_core

Overview:
- 8N1 UART receiver: serial pin in, parallel byte out.
- Sits directly upstream of the serial-to-Wishbone bridge, replacing its inline receive logic; the bridge consumes bytes through a valid/ready handshake.
- Provides an input synchronizer, glitch-rejecting start detection, mid-bit sampling, and framing-error and overrun reporting.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200); must be >= 4.
- CNT_W, 16, counter width; must satisfy 2**CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active high
- serial_rx  input  1  asynchronous UART line, idle high
- rx_data  output  8  received byte, LSB = first data bit
- rx_valid  output  1  rx_data holds an unconsumed byte
- rx_ready  input  1  consumer accepts the byte when rx_valid and rx_ready are both high
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: byte completed while the previous byte was still unconsumed
- busy  output  1  high in any state except IDLE

Behaviour:
- Reset values and reset rules:
  - All outputs reset to 0: rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Synchronizer flops reset to 1. State resets to IDLE.
  - Reset mid-frame abandons the frame; no pulse is produced.
- Synchronizer: 2 flip-flops on serial_rx; all logic uses the second stage, rxs. Pin-to-rxs latency is 2 cycles.
- IDLE:
  - Bit counter cleared.
  - rxs==0 -> START, baud counter loaded with CLKS_PER_BIT/2 - 1.
- START:
  - Counter decrements each cycle.
  - At 0: if rxs==0 -> DATA with counter = CLKS_PER_BIT-1; else -> IDLE (glitch rejected, no output).
- DATA:
  - At counter 0, sample rxs into shift register bit[bit_idx], LSB first, then reload CLKS_PER_BIT-1.
  - After 8th sample (bit_idx 7) -> STOP. bit_idx is 3 bits and must not wrap early.
- STOP: at counter 0, sample rxs.
  - Sample 1, rx_valid==0: rx_data<=shift, rx_valid<=1 next cycle -> IDLE.
  - Sample 1, rx_valid==1, and no acceptance this cycle: byte dropped, rx_data unchanged, overrun pulses 1 cycle -> IDLE.
  - Sample 1 and acceptance in the same cycle: acceptance wins the slot; new byte loaded, rx_valid stays 1, no overrun.
  - Sample 0: frame_err pulses 1 cycle, byte discarded -> BREAK.
- BREAK: wait for rxs==1 -> IDLE. A held-low line (break condition) yields exactly one frame_err.
- Handshake:
  - rx_valid clears the cycle after rx_valid&&rx_ready, unless a new byte loads in the same cycle.
  - rx_data is stable while rx_valid==1.
  - rx_ready while rx_valid==0 has no effect.
- Latency: rx_valid rises CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 3 cycles (+/-1) after the start edge at the pin.
- busy==(state!=IDLE).
- Back-to-back frames: after STOP the block returns to IDLE at mid-stop-bit and can detect a next start edge half a bit early; no idle gap is required.

Test Plan:
- CLKS_PER_BIT=16; send 8'hA5 (8N1), rx_ready held 1 -> rx_valid high exactly 1 cycle, rx_data=8'hA5, latency 8+144+3 +/-1 cycles, no frame_err/overrun.
- Send 8'h3C then 8'hC3 back-to-back, rx_ready=0 until both received -> rx_data=8'h3C stays stable, overrun pulses once at second STOP; assert rx_ready -> rx_valid falls next cycle.
- Drive rx low for 5 cycles then high (glitch < half bit) -> return to IDLE, no rx_valid, no frame_err, busy high for about 8 cycles.
- Send 8'h55 with stop bit forced 0, then hold line low 100 cycles -> exactly one frame_err pulse, no rx_valid; line high then 8'h01 -> rx_data=8'h01 received correctly.
- Assert rst mid-DATA of 8'hFF, then release and send 8'h12 -> outputs 0 during reset, next byte 8'h12 received, no spurious pulses.
- Send 8'h00 and 8'hFF with ready/valid coinciding at STOP of the second byte -> both accepted, no overrun.

Source files
------------

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with a two-flop input synchronizer,
// glitch-rejecting start detection and mid-bit sampling. Bytes are handed
// to the consumer over a valid/ready handshake. Framing errors and overruns
// are reported as one-cycle pulses.
// CLKS_PER_BIT must be >= 4 and 2**CNT_W must exceed CLKS_PER_BIT.
module uart_rx_core #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  // Half a bit lands the first sample mid start bit; full bits thereafter.
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             r_sync1;
  logic             r_rxs;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_rx_data;
  logic             r_rx_valid;
  logic             r_frame_err;
  logic             r_overrun;
  logic             r_busy;

  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_bit_idx_nxt;
  logic [7:0]       w_shift_nxt;
  logic [7:0]       w_rx_data_nxt;
  logic             w_rx_valid_nxt;
  logic             w_frame_err_nxt;
  logic             w_overrun_nxt;
  logic             w_accept;
  logic             w_cnt_zero;

  assign w_accept   = r_rx_valid & rx_ready;
  assign w_cnt_zero = (r_cnt == '0);

  // Two-stage synchronizer for the asynchronous line; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= serial_rx;
      r_rxs   <= r_sync1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'h00;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_overrun   <= w_overrun_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  // Next-state, bit timing, sampling and handshake logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_bit_idx_nxt   = r_bit_idx;
    w_shift_nxt     = r_shift;
    w_rx_data_nxt   = r_rx_data;
    w_rx_valid_nxt  = r_rx_valid;
    w_frame_err_nxt = 1'b0;
    w_overrun_nxt   = 1'b0;

    if (w_accept) begin
      w_rx_valid_nxt = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        w_bit_idx_nxt = 3'd0;
        if (!r_rxs) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = CNT_HALF;
        end
      end

      S_START: begin
        if (w_cnt_zero) begin
          // Line must still be low mid start bit, otherwise it was a glitch.
          if (!r_rxs) begin
            w_state_nxt = S_DATA;
            w_cnt_nxt   = CNT_FULL;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end

      S_DATA: begin
        if (w_cnt_zero) begin
          w_shift_nxt[r_bit_idx] = r_rxs;
          w_cnt_nxt              = CNT_FULL;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt   = S_STOP;
            w_bit_idx_nxt = 3'd0;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end

      S_STOP: begin
        if (w_cnt_zero) begin
          if (r_rxs) begin
            // A same-cycle acceptance frees the slot for the new byte.
            if (!r_rx_valid || w_accept) begin
              w_rx_data_nxt  = r_shift;
              w_rx_valid_nxt = 1'b1;
            end else begin
              w_overrun_nxt = 1'b1;
            end
            w_state_nxt = S_IDLE;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = S_BREAK;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end

      S_BREAK: begin
        // Hold off until the line returns high so a break reports once.
        if (r_rxs) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = r_busy;

endmodule
